sparse_coord_gen: RTL
=====================

# sparse_coord_gen

Cartesian-product coordinate generator for the sparse convolution datapath. It holds the compressed non-zero weights of one 3x3 kernel and expands each incoming non-zero activation against every stored weight. Each (activation, weight) pair is emitted with its output-map coordinate (x_cor, y_cor). The block sits directly upstream of the 12x12 one-hot select decoder and the partial-sum accumulator array, which consume x_cor/y_cor and the operand pair.

## Interface
- DATA_W, 8, activation and weight value width
- W_DEPTH, 9, max stored non-zero weights (3x3 kernel)
- GRID, 12, output map side; input map side is GRID+2 (valid 3x3 conv)

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- w_load  in  1  start weight load; clears weight list
- w_valid  in  1  weight entry write strobe
- w_data  in  DATA_W  weight value
- w_kx, w_ky  in  2 each  kernel offset, 0..2
- w_done  in  1  end of weight load
- w_ovf  out  1  sticky; write attempted with list full; cleared by w_load
- a_valid  in  1  activation offered
- a_ready  out  1  activation accepted when a_valid & a_ready
- a_data  in  DATA_W  activation value
- a_x, a_y  in  4 each  input coordinate, 0..13
- a_last  in  1  last activation of frame
- o_valid  out  1  product pair valid
- o_ready  in  1  downstream accepts pair
- o_act, o_wgt  out  DATA_W each  operand pair
- x_cor, y_cor  out  4 each  output coordinate, 0..11
- o_last  out  1  final stored weight of current activation
- frame_done  out  1  one-cycle pulse

## Operation
- FSM states: S_IDLE, S_LOAD, S_READY, S_EXPAND. Reset enters S_IDLE.
- S_IDLE/S_READY, w_load=1:
  - clear w_count and w_ovf; go to S_LOAD.
  - w_load is ignored in S_LOAD and S_EXPAND.
- S_LOAD:
  - w_valid writes entry[w_count] and increments w_count.
  - At w_count==W_DEPTH the write is dropped and w_ovf is set.
  - w_done goes to S_READY. If w_valid and w_done arrive in the same cycle, the write completes first.
- S_READY:
  - a_ready=1; a_ready is 0 in every other state.
  - On accept, register a_data/a_x/a_y/a_last, set idx=0, go to S_EXPAND.
  - If a_data==0 or w_count==0, the activation is consumed with no output and the state stays S_READY. frame_done pulses if a_last.
- S_EXPAND, candidate = entry[idx]:
  - ox = a_x − kx, oy = a_y − ky, computed as 5-bit signed.
  - in_range = ox,oy ∈ [0, GRID−1].
  - o_valid = in_range. Outputs are driven from registers only; there is no path from o_ready to o_valid.
  - Advance (idx+1) when !in_range or o_ready. Out-of-range pairs are skipped silently.
  - o_last = (idx == w_count−1).
  - Advancing from the last idx returns to S_READY. If the held a_last=1, frame_done pulses in that same cycle.
- Weights persist across frames until the next w_load.
- Reset mid-operation: the FSM aborts immediately. No partial output is held.

## Timing
- Reset values:
  - a_ready, o_valid, o_last, frame_done, w_ovf = 0
  - o_act, o_wgt, x_cor, y_cor = 0
  - w_count = 0; state = S_IDLE
- Activation accepted at cycle N → first candidate is evaluated at cycle N+1.
- Throughput: one pair per cycle while o_ready=1. Each skipped pair costs one bubble cycle.
- Per-activation cost: w_count cycles in S_EXPAND plus 1 cycle in S_READY, minimum.
- o_valid must stay high, with all outputs stable, until o_ready. Stalls are unbounded.
- frame_done is registered: high exactly one cycle, aligned with the transition to S_READY.

## Structure
- Shared package sparse_pkg:
  - GRID, K=3, COORD_W=4
  - state enum
  - packed weight-entry typedef {data, kx, ky}
- Sub-module wgt_regfile: W_DEPTH×entry register file with synchronous write, combinational read by idx, and w_count and w_ovf logic.

## Test plan
- Load 9 weights (all kx,ky); activation (a_x=5, a_y=5, data=3), o_ready=1 → 9 pairs on 9 consecutive cycles. Coordinates (5,5)…(3,3). o_last on the 9th.
- Activation (0,0) with full kernel → exactly 1 pair, (0,0) from kx=ky=0; 8 skip cycles. Activation (13,13) → 1 pair, (11,11).
- o_ready toggled pseudo-randomly → no pair lost or duplicated; outputs stable while o_valid & !o_ready.
- 10 w_valid writes → w_count=9, w_ovf=1. A following w_load clears w_ovf.
- Zero-valued activation with a_last=1 → accepted, no o_valid, frame_done pulses one cycle later.
- rst_n asserted mid-S_EXPAND → all outputs 0 asynchronously. After release: state S_IDLE, a_ready=0 until a new weight load.

Source files
------------

// File: rtl/sparse_coord_gen_pkg.sv
// Shared definitions for the sparse convolution coordinate generator.
//   GRID    : output map side (input map side is GRID+2)
//   K       : kernel side
//   COORD_W : width of x/y coordinates
//   KOFF_W  : width of a kernel offset (0..K-1)
//   state_t : generator FSM states
//   w_entry_t : one stored non-zero weight {data, kx, ky}
//   coord_sub : input coordinate minus kernel offset, with one sign bit
package sparse_pkg;

    localparam int GRID        = 12;
    localparam int K           = 3;
    localparam int COORD_W     = 4;
    localparam int KOFF_W      = 2;
    localparam int DATA_W_DEF  = 8;
    localparam int W_DEPTH_DEF = K * K;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_EXPAND
    } state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [KOFF_W-1:0]     kx;
        logic [KOFF_W-1:0]     ky;
    } w_entry_t;

    // Result is COORD_W+1 bits; the MSB set means the difference went negative.
    function automatic logic [COORD_W:0] coord_sub(input logic [COORD_W-1:0] a,
                                                   input logic [KOFF_W-1:0]  k);
        return {1'b0, a} - {{(COORD_W + 1 - KOFF_W){1'b0}}, k};
    endfunction

endpackage

// File: rtl/sparse_coord_gen_if.sv
// Activation-in / product-out handshake bundle of sparse_coord_gen.
//   a_valid/a_ready/a_data/a_x/a_y/a_last : activation stream into the generator
//   o_valid/o_ready/o_act/o_wgt/x_cor/y_cor/o_last : product pair stream out
//   master : the environment (activation source and pair sink)
//   slave  : the coordinate generator
interface sparse_coord_gen_if
    import sparse_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic               a_valid;
    logic               a_ready;
    logic [DATA_W-1:0]  a_data;
    logic [COORD_W-1:0] a_x;
    logic [COORD_W-1:0] a_y;
    logic               a_last;

    logic               o_valid;
    logic               o_ready;
    logic [DATA_W-1:0]  o_act;
    logic [DATA_W-1:0]  o_wgt;
    logic [COORD_W-1:0] x_cor;
    logic [COORD_W-1:0] y_cor;
    logic               o_last;

    modport master (
        output a_valid, a_data, a_x, a_y, a_last, o_ready,
        input  a_ready, o_valid, o_act, o_wgt, x_cor, y_cor, o_last
    );

    modport slave (
        input  a_valid, a_data, a_x, a_y, a_last, o_ready,
        output a_ready, o_valid, o_act, o_wgt, x_cor, y_cor, o_last
    );

endinterface

// File: rtl/sparse_coord_gen_wgt_regfile.sv
// Compressed kernel weight store.
//   clk, rst_n : clock, asynchronous active-low reset (count/ovf only)
//   clear      : empty the list and clear ovf
//   wr_en      : append wr_entry at position count
//   rd_idx     : combinational read address, rd_entry is '0 beyond W_DEPTH-1
//   count      : number of stored entries
//   ovf        : sticky, a write arrived while the list was full
module wgt_regfile
    import sparse_pkg::*;
#(
    parameter int W_DEPTH = W_DEPTH_DEF,
    parameter int CW      = $clog2(W_DEPTH_DEF + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          wr_en,
    input  w_entry_t      wr_entry,
    input  logic [CW-1:0] rd_idx,
    output w_entry_t      rd_entry,
    output logic [CW-1:0] count,
    output logic          ovf
);

    w_entry_t mem [W_DEPTH];
    logic     full;

    assign full = (count == CW'(W_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (wr_en) begin
            if (full) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    // Storage needs no reset: entries beyond count are never read as candidates.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < W_DEPTH; i++) begin
            if (wr_en && !clear && !full && (count == CW'(i))) begin
                mem[i] <= wr_entry;
            end
        end
    end

    always_comb begin
        rd_entry = '0;
        for (int unsigned i = 0; i < W_DEPTH; i++) begin
            if (rd_idx == CW'(i)) begin
                rd_entry = mem[i];
            end
        end
    end

endmodule

// File: rtl/sparse_coord_gen.sv
// Cartesian-product coordinate generator: expands each non-zero activation
// against every stored non-zero kernel weight and emits the pair together
// with its output-map coordinate.
//   clk, rst_n        : clock, asynchronous active-low reset
//   w_load            : start weight load (clears the list), in IDLE/READY only
//   w_valid/w_data/w_kx/w_ky : weight entry write
//   w_done            : end of weight load
//   w_ovf             : sticky write-while-full flag
//   bus (slave)       : activation stream in, product pair stream out
//   frame_done        : one-cycle pulse after the frame's last activation
module sparse_coord_gen #(
    parameter int DATA_W  = sparse_pkg::DATA_W_DEF,
    parameter int W_DEPTH = sparse_pkg::W_DEPTH_DEF,
    parameter int GRID    = sparse_pkg::GRID
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_load,
    input  logic              w_valid,
    input  logic [DATA_W-1:0] w_data,
    input  logic [1:0]        w_kx,
    input  logic [1:0]        w_ky,
    input  logic              w_done,
    output logic              w_ovf,
    sparse_coord_gen_if.slave bus,
    output logic              frame_done
);

    import sparse_pkg::*;

    localparam int                 CW     = $clog2(W_DEPTH + 1);
    localparam logic [COORD_W-1:0] XY_MAX = COORD_W'(GRID - 1);

    state_t state_q, state_d;

    logic [CW-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]  act_data_q, act_data_d;
    logic [COORD_W-1:0] act_x_q, act_x_d;
    logic [COORD_W-1:0] act_y_q, act_y_d;
    logic               act_last_q, act_last_d;

    logic               o_valid_q, o_valid_d;
    logic [DATA_W-1:0]  o_act_q, o_act_d;
    logic [DATA_W-1:0]  o_wgt_q, o_wgt_d;
    logic [COORD_W-1:0] o_x_q, o_x_d;
    logic [COORD_W-1:0] o_y_q, o_y_d;
    logic               o_last_q, o_last_d;
    logic               frame_done_q, frame_done_d;

    logic               rf_clear;
    logic               rf_wr;
    w_entry_t           wr_entry;
    w_entry_t           rd_entry;
    logic [CW-1:0]      rd_idx;
    logic [CW-1:0]      w_count;

    logic [DATA_W-1:0]  cand_act;
    logic [COORD_W-1:0] cand_x;
    logic [COORD_W-1:0] cand_y;
    logic [COORD_W:0]   ox;
    logic [COORD_W:0]   oy;
    logic               in_range;
    logic               load_cand;

    assign wr_entry.data = w_data;
    assign wr_entry.kx   = w_kx;
    assign wr_entry.ky   = w_ky;

    wgt_regfile #(
        .W_DEPTH (W_DEPTH),
        .CW      (CW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (rf_clear),
        .wr_en    (rf_wr),
        .wr_entry (wr_entry),
        .rd_idx   (rd_idx),
        .rd_entry (rd_entry),
        .count    (w_count),
        .ovf      (w_ovf)
    );

    // Output registers hold the candidate being presented; the next candidate
    // (index 0 on accept, idx+1 on advance) is evaluated a cycle ahead so every
    // output comes straight from a flop. A skipped candidate shows as a cycle
    // with o_valid low.
    assign rd_idx   = (state_q == S_EXPAND) ? idx_q + CW'(1) : '0;
    assign cand_act = (state_q == S_EXPAND) ? act_data_q : bus.a_data;
    assign cand_x   = (state_q == S_EXPAND) ? act_x_q : bus.a_x;
    assign cand_y   = (state_q == S_EXPAND) ? act_y_q : bus.a_y;

    assign ox       = coord_sub(cand_x, rd_entry.kx);
    assign oy       = coord_sub(cand_y, rd_entry.ky);
    assign in_range = !ox[COORD_W] && (ox[COORD_W-1:0] <= XY_MAX) &&
                      !oy[COORD_W] && (oy[COORD_W-1:0] <= XY_MAX);

    // w_load takes the FSM out of READY, so an activation is not accepted then.
    assign bus.a_ready = (state_q == S_READY) && !w_load;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        act_data_d   = act_data_q;
        act_x_d      = act_x_q;
        act_y_d      = act_y_q;
        act_last_d   = act_last_q;
        o_valid_d    = o_valid_q;
        o_act_d      = o_act_q;
        o_wgt_d      = o_wgt_q;
        o_x_d        = o_x_q;
        o_y_d        = o_y_q;
        o_last_d     = o_last_q;
        frame_done_d = 1'b0;
        rf_clear     = 1'b0;
        rf_wr        = 1'b0;
        load_cand    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_load) begin
                    rf_clear = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                rf_wr = w_valid;
                if (w_done) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (w_load) begin
                    rf_clear = 1'b1;
                    state_d  = S_LOAD;
                end else if (bus.a_valid) begin
                    act_data_d = bus.a_data;
                    act_x_d    = bus.a_x;
                    act_y_d    = bus.a_y;
                    act_last_d = bus.a_last;
                    if ((bus.a_data == '0) || (w_count == '0)) begin
                        frame_done_d = bus.a_last;
                    end else begin
                        state_d   = S_EXPAND;
                        idx_d     = '0;
                        load_cand = 1'b1;
                    end
                end
            end
            S_EXPAND: begin
                if (!o_valid_q || bus.o_ready) begin
                    if (idx_q == w_count - CW'(1)) begin
                        state_d      = S_READY;
                        frame_done_d = act_last_q;
                        o_valid_d    = 1'b0;
                        o_act_d      = '0;
                        o_wgt_d      = '0;
                        o_x_d        = '0;
                        o_y_d        = '0;
                        o_last_d     = 1'b0;
                    end else begin
                        idx_d     = idx_q + CW'(1);
                        load_cand = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_cand) begin
            o_valid_d = in_range;
            o_act_d   = in_range ? cand_act : '0;
            o_wgt_d   = in_range ? rd_entry.data : '0;
            o_x_d     = in_range ? ox[COORD_W-1:0] : '0;
            o_y_d     = in_range ? oy[COORD_W-1:0] : '0;
            o_last_d  = (rd_idx == w_count - CW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            act_data_q   <= '0;
            act_x_q      <= '0;
            act_y_q      <= '0;
            act_last_q   <= 1'b0;
            o_valid_q    <= 1'b0;
            o_act_q      <= '0;
            o_wgt_q      <= '0;
            o_x_q        <= '0;
            o_y_q        <= '0;
            o_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            act_data_q   <= act_data_d;
            act_x_q      <= act_x_d;
            act_y_q      <= act_y_d;
            act_last_q   <= act_last_d;
            o_valid_q    <= o_valid_d;
            o_act_q      <= o_act_d;
            o_wgt_q      <= o_wgt_d;
            o_x_q        <= o_x_d;
            o_y_q        <= o_y_d;
            o_last_q     <= o_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_act   = o_act_q;
    assign bus.o_wgt   = o_wgt_q;
    assign bus.x_cor   = o_x_q;
    assign bus.y_cor   = o_y_q;
    assign bus.o_last  = o_last_q;
    assign frame_done  = frame_done_q;

endmodule
